// File: rtl/db15_pkg.sv
// Shared constants and state encoding for the DB15 serial joystick link.
// Bit positions match the console-side receiver so both ends agree on the map.
package db15_pkg;

  localparam int FRAME_BITS  = 32;
  localparam int PLAYER_BITS = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam int BTN_RIGHT = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_UP    = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_D     = 7;
  localparam int BTN_E     = 8;
  localparam int BTN_F     = 9;
  localparam int BTN_START = 10;
  localparam int BTN_LSH   = 11;

endpackage

// File: rtl/db15_sync_filter.sv
// Synchronizer, N-sample agreement filter and rising-edge detect for one remote line.
// All flops preset to 1, the idle level of the DB15 lines.
module db15_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FILTER_LEN-1:0]  hist_q, hist_d;
  logic                   filt_q, filt_d;
  logic                   all_hi, all_lo;

  always_comb begin
    sync_d = SYNC_STAGES'({sync_q, pin_i});
    hist_d = FILTER_LEN'({hist_q, sync_q[SYNC_STAGES-1]});
    all_hi = &hist_q;
    all_lo = ~|hist_q;
    filt_d = filt_q;
    if (all_hi)      filt_d = 1'b1;
    else if (all_lo) filt_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_q <= '1;
      hist_q <= '1;
      filt_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      filt_q <= filt_d;
    end
  end

  // Rise fires in the cycle the filter agrees, so the FSM acts on the same edge the level updates.
  assign level_o = filt_q;
  assign rise_o  = all_hi & ~filt_q;

endmodule

// File: rtl/db15_joy_tx.sv
// Device-side DB15 joystick responder: shifts ~{joy1,joy2} MSB first under remote load/clock.
// Optional idle timeout and link_active_o port enabled by defining DB15TX_TIMEOUT_EN.
module db15_joy_tx
  import db15_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
`ifdef DB15TX_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 65536
`endif
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [PLAYER_BITS-1:0] joy1_i,
  input  logic [PLAYER_BITS-1:0] joy2_i,
  input  logic                   joy_clk_i,
  input  logic                   joy_load_i,
  output logic                   joy_data_o,
  output logic                   busy_o,
  output logic                   frame_done_o
`ifdef DB15TX_TIMEOUT_EN
  , output logic                 link_active_o
`endif
);

  logic clk_lvl, clk_rise, load_lvl, load_rise, load_low;
  logic unused_edges;

  db15_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .pin_i    (joy_clk_i),
    .level_o  (clk_lvl),
    .rise_o   (clk_rise)
  );

  db15_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_load_filt (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .pin_i    (joy_load_i),
    .level_o  (load_lvl),
    .rise_o   (load_rise)
  );

  assign load_low     = ~load_lvl;
  assign unused_edges = clk_lvl ^ load_rise;

  state_t                  state_q, state_d;
  logic [FRAME_BITS-1:0]   sr_q, sr_d;
  logic [5:0]              cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
`ifdef DB15TX_TIMEOUT_EN
  logic [16:0]             idle_q, idle_d;
  logic                    link_q, link_d;
`endif

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    // Load has priority over everything, including a coincident clock rise.
    if (load_low) begin
      sr_d    = ~{joy1_i, joy2_i};
      cnt_d   = 6'd0;
      busy_d  = 1'b1;
      state_d = LOAD;
    end else begin
      case (state_q)
        IDLE: if (clk_rise) sr_d = {sr_q[FRAME_BITS-2:0], 1'b1};
        LOAD: state_d = SHIFT;
        SHIFT: if (clk_rise) begin
          sr_d  = {sr_q[FRAME_BITS-2:0], 1'b1};
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'(FRAME_BITS - 1)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef DB15TX_TIMEOUT_EN
    link_d = done_d ? 1'b1 : link_q;
    idle_d = idle_q;
    if (clk_rise || load_low)  idle_d = 17'd0;
    else if (busy_q || link_q) idle_d = idle_q + 17'd1;
    if (!load_low && idle_q == 17'(TIMEOUT_CYC)) begin
      state_d = IDLE;
      sr_d    = '1;
      cnt_d   = 6'd0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      link_d  = 1'b0;
      idle_d  = 17'd0;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      sr_q    <= '1;
      cnt_q   <= 6'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DB15TX_TIMEOUT_EN
      idle_q  <= 17'd0;
      link_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DB15TX_TIMEOUT_EN
      idle_q  <= idle_d;
      link_q  <= link_d;
`endif
    end
  end

  assign joy_data_o   = sr_q[FRAME_BITS-1];
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
`ifdef DB15TX_TIMEOUT_EN
  assign link_active_o = link_q;
`endif

endmodule
